// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipelined RV32 control unit.
//   - Opcode constants for the decoded instruction classes.
//   - ALUOp encodings (00 add, 01 sub/compare, 10 R-funct, 11 I-funct).
//   - Forwarding-select encodings (FWD_RF, FWD_MEM, FWD_WB).
//   - ctrl_bundle_t control bundle, CTRL_NOP and the opcode decoder.
package pipe_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  // Full-opcode decode; anything unrecognised becomes a NOP bundle.
  function automatic ctrl_bundle_t decode_op(input logic [6:0] op);
    ctrl_bundle_t c;
    c = CTRL_NOP;
    unique case (op)
      OPC_RTYPE: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_RFUNCT;
      end
      OPC_IALU: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_IFUNCT;
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_op     = ALUOP_ADD;
      end
      OPC_STORE: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: purely combinational stall and operand-forwarding logic.
// Configuration macro: PIPE_CTRL_FWD_EN
//   defined   - forwarding from EX/MEM and MEM/WB; only load-use hazards stall.
//   undefined - forwarding tied to register file; any RAW hazard against an
//               in-flight writer in EX or MEM stalls.
// Ports:
//   rs1_id_i, rs2_id_i    ID-stage source registers
//   mem_read_ex_i         load in EX
//   reg_write_ex_i        EX instruction writes a register
//   rd_ex_i               EX destination
//   rs1_ex_i, rs2_ex_i    EX-stage source registers
//   reg_write_mem_i       MEM instruction writes a register
//   rd_mem_i              MEM destination
//   reg_write_wb_i        WB instruction writes a register
//   rd_wb_i               WB destination
//   stall_o               hold PC and IF/ID, bubble into ID/EX
//   fwd_a_o, fwd_b_o      EX operand source selects
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1_id_i,
  input  logic [REG_AW-1:0] rs2_id_i,
  input  logic              mem_read_ex_i,
  input  logic              reg_write_ex_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic [REG_AW-1:0] rs1_ex_i,
  input  logic [REG_AW-1:0] rs2_ex_i,
  input  logic              reg_write_mem_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic              reg_write_wb_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  output logic              stall_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  // A producer only counts when it names a real register; x0 never matches.
  function automatic logic hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

`ifdef PIPE_CTRL_FWD_EN

  // MEM is checked first so the youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic              wr_mem,
                                         input logic [REG_AW-1:0] rd_mem,
                                         input logic              wr_wb,
                                         input logic [REG_AW-1:0] rd_wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_mem && hit(rd_mem, rs)) begin
      sel = FWD_MEM;
    end else if (wr_wb && hit(rd_wb, rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic unused_reg_write_ex;
  assign unused_reg_write_ex = reg_write_ex_i;

  always_comb begin
    stall_o = mem_read_ex_i && (hit(rd_ex_i, rs1_id_i) || hit(rd_ex_i, rs2_id_i));
    fwd_a_o = fwd_sel(rs1_ex_i, reg_write_mem_i, rd_mem_i, reg_write_wb_i, rd_wb_i);
    fwd_b_o = fwd_sel(rs2_ex_i, reg_write_mem_i, rd_mem_i, reg_write_wb_i, rd_wb_i);
  end

`else

  // WB is not checked: the register file writes before it reads.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_read_ex_i, rs1_ex_i, rs2_ex_i, reg_write_wb_i, rd_wb_i};

  always_comb begin
    stall_o = (reg_write_ex_i  && (hit(rd_ex_i, rs1_id_i)  || hit(rd_ex_i, rs2_id_i))) ||
              (reg_write_mem_i && (hit(rd_mem_i, rs1_id_i) || hit(rd_mem_i, rs2_id_i)));
    fwd_a_o = FWD_RF;
    fwd_b_o = FWD_RF;
  end

`endif

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for the five-stage RV32 core.
// Decodes the ID opcode and carries the control bundle and register addresses
// through ID/EX, EX/MEM and MEM/WB; produces stall, flush and forward selects.
// Configuration macro: PIPE_CTRL_FWD_EN (enables operand forwarding, see
// pipe_ctrl_hazard).
// Ports:
//   clk_i                        clock, rising edge
//   rst_i                        synchronous reset, active-high
//   Op_i                         ID-stage opcode
//   RS1addr_i, RS2addr_i         ID-stage source registers
//   RDaddr_i                     ID-stage destination register
//   Equal_i                      ID-stage branch compare result
//   Stall_o                      hold PC and IF/ID, bubble into ID/EX
//   Flush_o                      clear IF/ID on a taken branch
//   ALUOp_EX_o, ALUSrc_EX_o      EX-stage controls
//   MemRead_MEM_o, MemWrite_MEM_o MEM-stage controls
//   MemtoReg_WB_o, RegWrite_WB_o WB-stage controls
//   RDaddr_WB_o                  WB destination register
//   ForwardA_o, ForwardB_o       EX operand source selects
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 7,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic [REG_AW-1:0]  RS1addr_i,
  input  logic [REG_AW-1:0]  RS2addr_i,
  input  logic [REG_AW-1:0]  RDaddr_i,
  input  logic               Equal_i,
  output logic               Stall_o,
  output logic               Flush_o,
  output logic [ALUOP_W-1:0] ALUOp_EX_o,
  output logic               ALUSrc_EX_o,
  output logic               MemRead_MEM_o,
  output logic               MemWrite_MEM_o,
  output logic               MemtoReg_WB_o,
  output logic               RegWrite_WB_o,
  output logic [REG_AW-1:0]  RDaddr_WB_o,
  output logic [1:0]         ForwardA_o,
  output logic [1:0]         ForwardB_o
);

  ctrl_bundle_t id_ctrl;
  logic         hazard_stall;

  // ID/EX
  ctrl_bundle_t      ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

  // EX/MEM
  logic              mem_mem_read_q, mem_mem_read_d;
  logic              mem_mem_write_q, mem_mem_write_d;
  logic              mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic              mem_reg_write_q, mem_reg_write_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;

  // MEM/WB
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

  // Branch is resolved in ID; the copy in EX has no consumer.
  logic unused_ex_branch;
  assign unused_ex_branch = ex_ctrl_q.branch;

  pipe_ctrl_hazard #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .rs1_id_i        (RS1addr_i),
    .rs2_id_i        (RS2addr_i),
    .mem_read_ex_i   (ex_ctrl_q.mem_read),
    .reg_write_ex_i  (ex_ctrl_q.reg_write),
    .rd_ex_i         (ex_rd_q),
    .rs1_ex_i        (ex_rs1_q),
    .rs2_ex_i        (ex_rs2_q),
    .reg_write_mem_i (mem_reg_write_q),
    .rd_mem_i        (mem_rd_q),
    .reg_write_wb_i  (wb_reg_write_q),
    .rd_wb_i         (wb_rd_q),
    .stall_o         (hazard_stall),
    .fwd_a_o         (ForwardA_o),
    .fwd_b_o         (ForwardB_o)
  );

  always_comb begin
    id_ctrl = decode_op(Op_i);
    // Reset masks stall/flush so a pending hazard from pre-reset state is dropped.
    Stall_o = hazard_stall & ~rst_i;
    // Stall wins: the branch is re-evaluated once the hazard clears.
    Flush_o = id_ctrl.branch & Equal_i & ~Stall_o & ~rst_i;
  end

  always_comb begin
    // The bubble keeps the source addresses; only the bundle and RD are cleared.
    ex_ctrl_d = Stall_o ? CTRL_NOP : id_ctrl;
    ex_rd_d   = Stall_o ? '0 : RDaddr_i;
    ex_rs1_d  = RS1addr_i;
    ex_rs2_d  = RS2addr_i;

    mem_mem_read_d   = ex_ctrl_q.mem_read;
    mem_mem_write_d  = ex_ctrl_q.mem_write;
    mem_mem_to_reg_d = ex_ctrl_q.mem_to_reg;
    mem_reg_write_d  = ex_ctrl_q.reg_write;
    mem_rd_d         = ex_rd_q;

    wb_mem_to_reg_d = mem_mem_to_reg_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_rd_d         = mem_rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_q        <= CTRL_NOP;
      ex_rs1_q         <= '0;
      ex_rs2_q         <= '0;
      ex_rd_q          <= '0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_rd_q         <= '0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_rd_q          <= '0;
    end else begin
      ex_ctrl_q        <= ex_ctrl_d;
      ex_rs1_q         <= ex_rs1_d;
      ex_rs2_q         <= ex_rs2_d;
      ex_rd_q          <= ex_rd_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_rd_q         <= mem_rd_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_rd_q          <= wb_rd_d;
    end
  end

  always_comb begin
    ALUOp_EX_o     = ex_ctrl_q.alu_op;
    ALUSrc_EX_o    = ex_ctrl_q.alu_src;
    MemRead_MEM_o  = mem_mem_read_q;
    MemWrite_MEM_o = mem_mem_write_q;
    MemtoReg_WB_o  = wb_mem_to_reg_q;
    RegWrite_WB_o  = wb_reg_write_q;
    RDaddr_WB_o    = wb_rd_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Expected stage controls are produced by a
// small decode model and queued as each instruction enters ID/EX; the queue
// entries are compared as they reach EX, MEM and WB.
module tb_pipe_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] Op_i;
  logic [4:0] RS1addr_i, RS2addr_i, RDaddr_i;
  logic       Equal_i;
  logic       Stall_o, Flush_o;
  logic [1:0] ALUOp_EX_o;
  logic       ALUSrc_EX_o, MemRead_MEM_o, MemWrite_MEM_o, MemtoReg_WB_o, RegWrite_WB_o;
  logic [4:0] RDaddr_WB_o;
  logic [1:0] ForwardA_o, ForwardB_o;

  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  pipe_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Op_i           (Op_i),
    .RS1addr_i      (RS1addr_i),
    .RS2addr_i      (RS2addr_i),
    .RDaddr_i       (RDaddr_i),
    .Equal_i        (Equal_i),
    .Stall_o        (Stall_o),
    .Flush_o        (Flush_o),
    .ALUOp_EX_o     (ALUOp_EX_o),
    .ALUSrc_EX_o    (ALUSrc_EX_o),
    .MemRead_MEM_o  (MemRead_MEM_o),
    .MemWrite_MEM_o (MemWrite_MEM_o),
    .MemtoReg_WB_o  (MemtoReg_WB_o),
    .RegWrite_WB_o  (RegWrite_WB_o),
    .RDaddr_WB_o    (RDaddr_WB_o),
    .ForwardA_o     (ForwardA_o),
    .ForwardB_o     (ForwardB_o)
  );

  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd);
    exp_t e;
    e    = '0;
    e.rd = rd;
    case (op)
      OP_R:  begin e.reg_write = 1'b1; e.alu_op = 2'b10; end
      OP_I:  begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_op = 2'b11; end
      OP_LD: begin
        e.reg_write = 1'b1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
      end
      OP_SW: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
      OP_BR: e.alu_op = 2'b01;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL step %0d %s: observed=%0h expected=%0h", step_no, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive ID inputs, check at the falling edge, then advance the
  // scoreboard by the instruction that enters ID/EX (a bubble when stalled).
  task automatic step(input logic rst, input logic [6:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic eq,
                      input logic st, input logic fl, input logic [1:0] fa,
                      input logic [1:0] fb);
    exp_t e_ex, e_mem, e_wb;
    step_no++;
    rst_i = rst; Op_i = op; RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd; Equal_i = eq;
    @(negedge clk_i);
    chk("stall", {7'd0, Stall_o}, {7'd0, st});
    chk("flush", {7'd0, Flush_o}, {7'd0, fl});
    if (!rst) begin
      e_wb  = sb[0];
      e_mem = sb[1];
      e_ex  = sb[2];
      chk("fwd_a", {6'd0, ForwardA_o}, {6'd0, fa});
      chk("fwd_b", {6'd0, ForwardB_o}, {6'd0, fb});
      chk("aluop_ex", {6'd0, ALUOp_EX_o}, {6'd0, e_ex.alu_op});
      chk("alusrc_ex", {7'd0, ALUSrc_EX_o}, {7'd0, e_ex.alu_src});
      chk("memread_mem", {7'd0, MemRead_MEM_o}, {7'd0, e_mem.mem_read});
      chk("memwrite_mem", {7'd0, MemWrite_MEM_o}, {7'd0, e_mem.mem_write});
      chk("memtoreg_wb", {7'd0, MemtoReg_WB_o}, {7'd0, e_wb.mem_to_reg});
      chk("regwrite_wb", {7'd0, RegWrite_WB_o}, {7'd0, e_wb.reg_write});
      chk("rd_wb", {3'd0, RDaddr_WB_o}, {3'd0, e_wb.rd});
    end
    @(posedge clk_i);
    #1;
    if (rst) begin
      sb.delete();
      repeat (3) sb.push_back('0);
    end else begin
      void'(sb.pop_front());
      sb.push_back(st ? exp_t'('0) : model(op, rd));
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    rst_i = 1'b1; Op_i = OP_NOP; RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = '0; Equal_i = 1'b0;

    // Reset with a taken branch on the inputs: no flush, no stall.
    step(1, OP_BR, 5'd1, 5'd2, 5'd0, 1, 0, 0, 2'b00, 2'b00);
    step(1, OP_BR, 5'd1, 5'd2, 5'd0, 1, 0, 0, 2'b00, 2'b00);

    // add x3,x1,x2 then a store; latency checked through the scoreboard.
    step(0, OP_R,  5'd1, 5'd2, 5'd3, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_SW, 5'd1, 5'd2, 5'd0, 0, 0, 0, 2'b00, 2'b00);
    nops(4);

`ifdef PIPE_CTRL_FWD_EN
    // Load-use: one stall, then 10 (bubble vs load in MEM), then 01.
    step(0, OP_LD, 5'd1, 5'd0, 5'd5, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd5, 5'd2, 5'd6, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd5, 5'd2, 5'd6, 0, 0, 0, 2'b10, 2'b00);
    step(0, OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b01, 2'b00);
    nops(3);
    // ALU RAW on RS2 forwards from MEM with no stall.
    step(0, OP_R,  5'd1, 5'd2, 5'd4, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd3, 5'd4, 5'd7, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b10);
    nops(3);
    // Both MEM and WB write x8: MEM wins.
    step(0, OP_R,  5'd1, 5'd2, 5'd8, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_I,  5'd1, 5'd0, 5'd8, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd8, 5'd8, 5'd9, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b10, 2'b10);
    nops(3);
`else
    // Load-use without forwarding: stalls while the load is in EX and in MEM.
    step(0, OP_LD, 5'd1, 5'd0, 5'd5, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd5, 5'd2, 5'd6, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd5, 5'd2, 5'd6, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd5, 5'd2, 5'd6, 0, 0, 0, 2'b00, 2'b00);
    nops(3);
    // ALU RAW on RS2: two stall cycles, forwards stay 00.
    step(0, OP_R,  5'd1, 5'd2, 5'd4, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd3, 5'd4, 5'd7, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd3, 5'd4, 5'd7, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd3, 5'd4, 5'd7, 0, 0, 0, 2'b00, 2'b00);
    nops(3);
    step(0, OP_R,  5'd1, 5'd2, 5'd8, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_I,  5'd1, 5'd0, 5'd8, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd8, 5'd8, 5'd9, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd8, 5'd8, 5'd9, 0, 1, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd8, 5'd8, 5'd9, 0, 0, 0, 2'b00, 2'b00);
    nops(3);
`endif

    // Branch taken / not taken.
    step(0, OP_BR, 5'd1, 5'd2, 5'd0, 1, 0, 1, 2'b00, 2'b00);
    step(0, OP_BR, 5'd1, 5'd2, 5'd0, 0, 0, 0, 2'b00, 2'b00);
    nops(3);

    // Branch behind a load: flush is held off until the stall clears.
    step(0, OP_LD, 5'd1, 5'd0, 5'd5, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_BR, 5'd5, 5'd2, 5'd0, 1, 1, 0, 2'b00, 2'b00);
`ifdef PIPE_CTRL_FWD_EN
    step(0, OP_BR, 5'd5, 5'd2, 5'd0, 1, 0, 1, 2'b10, 2'b00);
    step(0, OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b01, 2'b00);
`else
    step(0, OP_BR, 5'd5, 5'd2, 5'd0, 1, 1, 0, 2'b00, 2'b00);
    step(0, OP_BR, 5'd5, 5'd2, 5'd0, 1, 0, 1, 2'b00, 2'b00);
`endif
    nops(3);

    // x0 never stalls or forwards; an unknown opcode carries an all-zero bundle.
    step(0, OP_R,   5'd1, 5'd2, 5'd0,  0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,   5'd0, 5'd0, 5'd10, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_LD,  5'd1, 5'd0, 5'd0,  0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,   5'd0, 5'd0, 5'd11, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_BAD, 5'd9, 5'd9, 5'd9,  0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,   5'd9, 5'd0, 5'd12, 0, 0, 0, 2'b00, 2'b00);
    nops(4);

    // Reset during a load-use stall drops the stall and clears every stage.
    step(0, OP_LD, 5'd1, 5'd0, 5'd5, 0, 0, 0, 2'b00, 2'b00);
    step(1, OP_R,  5'd5, 5'd2, 5'd6, 0, 0, 0, 2'b00, 2'b00);
    step(0, OP_R,  5'd5, 5'd2, 5'd6, 0, 0, 0, 2'b00, 2'b00);
    nops(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
